// File: rtl/dl_pkg.sv
// Shared Data Link Layer types for the receive-side Ack/Nak path.
package dl_pkg;

  localparam int SEQ_W = 12;

  typedef enum logic {
    DLLP_ACK = 1'b0,
    DLLP_NAK = 1'b1
  } dllp_kind_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK_WAIT = 2'd1,
    SEND_ACK = 2'd2,
    SEND_NAK = 2'd3
  } acknak_state_e;

endpackage

// File: rtl/acknak_lat_timer.sv
// AckNak latency timer: runs from the first unacked good TLP, flags expiry
// and holds that flag until the next Ack/Nak transfer clears it.
module acknak_lat_timer #(
  parameter int LAT_W = 10,
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear,
  output logic expired
);

  localparam logic [LAT_W-1:0] LAST = LAT_W'(LIMIT - 1);

  logic [LAT_W-1:0] lat_cnt;
  logic             lat_run;

  // A start coinciding with a clear re-arms for the TLP that just arrived.
  // The count saturates at LAST so expiry stays visible until serviced.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lat_run <= 1'b0;
      lat_cnt <= '0;
    end else if (start && (clear || !lat_run)) begin
      lat_run <= 1'b1;
      lat_cnt <= '0;
    end else if (clear) begin
      lat_run <= 1'b0;
      lat_cnt <= '0;
    end else if (lat_run && (lat_cnt != LAST)) begin
      lat_cnt <= lat_cnt + 1'b1;
    end
  end

  assign expired = lat_run && (lat_cnt == LAST);

endmodule

// File: rtl/ack_nak_scheduler.sv
// Receive-side Ack/Nak DLLP scheduler: coalesces Acks, enforces the AckNak
// latency timer, gives Nak priority and issues one Nak per episode.
module ack_nak_scheduler
  import dl_pkg::*;
#(
  parameter int SEQ_W         = dl_pkg::SEQ_W,
  parameter int LAT_W         = 10,
  parameter int ACK_LAT_LIMIT = 255,
  parameter int COALESCE_MAX  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dl_up,
  input  logic             schedule_ack,
  input  logic             nak_scheduled,
  input  logic [SEQ_W-1:0] req_seq_num,
  input  logic             lat_timer_start,
  output logic             dllp_vld,
  output logic             dllp_is_nak,
  output logic [SEQ_W-1:0] dllp_seq,
  input  logic             dllp_rdy,
  output logic             ack_pending,
  output logic             nak_sent
);

  localparam logic [2:0] COAL_LIM = 3'(COALESCE_MAX);

  acknak_state_e    state;
  dllp_kind_e       dllp_kind;
  logic [SEQ_W-1:0] pend_seq;
  logic             pend_vld;
  logic [2:0]       coal_cnt;
  logic             lat_expired;
  logic             xfer;
  logic             nak_req;

  assign xfer    = dllp_vld && dllp_rdy;
  assign nak_req = nak_scheduled && !nak_sent && (state != SEND_NAK);

  acknak_lat_timer #(
    .LAT_W (LAT_W),
    .LIMIT (ACK_LAT_LIMIT)
  ) u_lat_timer (
    .clk     (clk),
    .rst     (rst),
    .start   (lat_timer_start && dl_up),
    .clear   (xfer || !dl_up),
    .expired (lat_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst || !dl_up) begin
      state     <= IDLE;
      dllp_kind <= DLLP_ACK;
      dllp_vld  <= 1'b0;
      dllp_seq  <= '0;
      pend_seq  <= '0;
      pend_vld  <= 1'b0;
      coal_cnt  <= '0;
      nak_sent  <= 1'b0;
    end else begin
      if (schedule_ack) begin
        pend_seq <= req_seq_num;
        pend_vld <= 1'b1;
        if (coal_cnt != 3'd7) coal_cnt <= coal_cnt + 3'd1;
      end
      if (!nak_scheduled) nak_sent <= 1'b0;

      // Entry assignments below override the capture above, so a Nak
      // swallows a same-cycle Ack and an Ack entry folds in a same-cycle one.
      case (state)
        IDLE, ACK_WAIT: begin
          if (nak_req) begin
            state     <= SEND_NAK;
            dllp_kind <= DLLP_NAK;
            dllp_seq  <= req_seq_num;
            dllp_vld  <= 1'b1;
            pend_vld  <= 1'b0;
            coal_cnt  <= '0;
          end else if (state == IDLE) begin
            if (pend_vld) state <= ACK_WAIT;
          end else if (lat_expired || (coal_cnt >= COAL_LIM)) begin
            state     <= SEND_ACK;
            dllp_kind <= DLLP_ACK;
            dllp_seq  <= schedule_ack ? req_seq_num : pend_seq;
            dllp_vld  <= 1'b1;
            pend_vld  <= 1'b0;
            coal_cnt  <= '0;
          end
        end
        SEND_ACK: begin
          if (xfer) begin
            dllp_vld <= 1'b0;
            state    <= (pend_vld || schedule_ack) ? ACK_WAIT : IDLE;
          end
        end
        SEND_NAK: begin
          if (xfer) begin
            dllp_vld <= 1'b0;
            state    <= IDLE;
            if (nak_scheduled) nak_sent <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dllp_is_nak = (dllp_kind == DLLP_NAK);
  assign ack_pending = pend_vld || ((state == SEND_ACK) && dllp_vld);

endmodule

// File: tb/tb_ack_nak_scheduler.sv
// Directed bench for ack_nak_scheduler with a DLLP scoreboard.
module tb_ack_nak_scheduler;

  localparam int SEQ_W = 12;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             dl_up = 1'b0;
  logic             schedule_ack = 1'b0;
  logic             nak_scheduled = 1'b0;
  logic [SEQ_W-1:0] req_seq_num = '0;
  logic             lat_timer_start = 1'b0;
  logic             dllp_vld;
  logic             dllp_is_nak;
  logic [SEQ_W-1:0] dllp_seq;
  logic             dllp_rdy = 1'b0;
  logic             ack_pending;
  logic             nak_sent;

  typedef struct packed {
    logic             is_nak;
    logic [SEQ_W-1:0] seq;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ack_nak_scheduler #(
    .SEQ_W         (SEQ_W),
    .LAT_W         (10),
    .ACK_LAT_LIMIT (16),
    .COALESCE_MAX  (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .dl_up           (dl_up),
    .schedule_ack    (schedule_ack),
    .nak_scheduled   (nak_scheduled),
    .req_seq_num     (req_seq_num),
    .lat_timer_start (lat_timer_start),
    .dllp_vld        (dllp_vld),
    .dllp_is_nak     (dllp_is_nak),
    .dllp_seq        (dllp_seq),
    .dllp_rdy        (dllp_rdy),
    .ack_pending     (ack_pending),
    .nak_sent        (nak_sent)
  );

  // Transfer monitor: inputs change just after posedge, so vld&&rdy at the
  // negedge means a transfer at the coming posedge.
  always @(negedge clk) begin
    if (rst && dl_up && dllp_vld && dllp_rdy) begin
      total++;
      assert (exp_q.size() != 0)
      else begin
        bad++;
        $error("FAIL unexpected_dllp obs=nak%0d/seq%0h exp=none", dllp_is_nak, dllp_seq);
      end
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        total++;
        assert ({dllp_is_nak, dllp_seq} === e)
        else begin
          bad++;
          $error("FAIL dllp_payload obs=nak%0d/seq%0h exp=nak%0d/seq%0h",
                 dllp_is_nak, dllp_seq, e.is_nak, e.seq);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_vld(input string tag, input int budget);
    int n = 0;
    while (!dllp_vld && n < budget) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, dllp_vld}, 32'd1);
  endtask

  task automatic pulse_ack(input logic [SEQ_W-1:0] seq, input logic start);
    schedule_ack    = 1'b1;
    req_seq_num     = seq;
    lat_timer_start = start;
    tick();
    schedule_ack    = 1'b0;
    lat_timer_start = 1'b0;
  endtask

  initial begin
    int seen;

    // Reset
    ticks(2);
    chk("rst_vld", {31'd0, dllp_vld}, 0);
    chk("rst_is_nak", {31'd0, dllp_is_nak}, 0);
    chk("rst_seq", {20'd0, dllp_seq}, 0);
    chk("rst_ack_pending", {31'd0, ack_pending}, 0);
    chk("rst_nak_sent", {31'd0, nak_sent}, 0);
    rst   = 1'b1;
    dl_up = 1'b1;
    tick();

    // Link-down while an Ack is held by backpressure
    dllp_rdy = 1'b0;
    for (int s = 0; s < 4; s++) begin
      schedule_ack = 1'b1;
      req_seq_num  = SEQ_W'(s);
      tick();
    end
    schedule_ack = 1'b0;
    wait_vld("dlup_ack_raised", 10);
    chk("dlup_hold_seq", {20'd0, dllp_seq}, 3);
    dl_up = 1'b0;
    tick();
    chk("dlup_vld", {31'd0, dllp_vld}, 0);
    chk("dlup_ack_pending", {31'd0, ack_pending}, 0);
    dl_up = 1'b1;
    tick();

    // Coalescing: four Acks, one DLLP carrying the newest seq
    dllp_rdy = 1'b1;
    exp_q.push_back('{is_nak: 1'b0, seq: 12'd3});
    for (int s = 0; s < 4; s++) begin
      pulse_ack(SEQ_W'(s), 1'b0);
      tick();
    end
    ticks(20);
    chk("coal_q_drained", exp_q.size(), 0);
    chk("coal_ack_pending", {31'd0, ack_pending}, 0);

    // Latency timer expiry: dllp_vld first appears 17 cycles after the start
    exp_q.push_back('{is_nak: 1'b0, seq: 12'd7});
    pulse_ack(12'd7, 1'b1);
    ticks(15);
    chk("lat_not_early", {31'd0, dllp_vld}, 0);
    tick();
    chk("lat_at_17", {31'd0, dllp_vld}, 1);
    chk("lat_seq", {20'd0, dllp_seq}, 7);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (dllp_vld) seen++;
    end
    chk("lat_cleared", seen, 0);
    chk("lat_q_drained", exp_q.size(), 0);

    // Nak priority and single-Nak suppression
    pulse_ack(12'd5, 1'b0);
    ticks(2);
    chk("nak_pre_pending", {31'd0, ack_pending}, 1);
    exp_q.push_back('{is_nak: 1'b1, seq: 12'd5});
    nak_scheduled = 1'b1;
    req_seq_num   = 12'd5;
    wait_vld("nak_raised", 5);
    chk("nak_is_nak", {31'd0, dllp_is_nak}, 1);
    tick();
    chk("nak_sent_set", {31'd0, nak_sent}, 1);
    chk("nak_drop_ack", {31'd0, ack_pending}, 0);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (dllp_vld) seen++;
    end
    chk("nak_suppress", seen, 0);
    nak_scheduled = 1'b0;
    tick();
    chk("nak_sent_clear", {31'd0, nak_sent}, 0);
    exp_q.push_back('{is_nak: 1'b1, seq: 12'd9});
    nak_scheduled = 1'b1;
    req_seq_num   = 12'd9;
    wait_vld("nak2_raised", 5);
    tick();
    chk("nak2_sent", {31'd0, nak_sent}, 1);
    nak_scheduled = 1'b0;
    ticks(2);
    chk("nak_q_drained", exp_q.size(), 0);

    // Backpressure: payload stays seq 2 while a seq 3 Ack arrives
    dllp_rdy = 1'b0;
    exp_q.push_back('{is_nak: 1'b0, seq: 12'd2});
    exp_q.push_back('{is_nak: 1'b0, seq: 12'd3});
    pulse_ack(12'd2, 1'b1);
    wait_vld("bp_raised", 30);
    pulse_ack(12'd3, 1'b0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (!dllp_vld || dllp_seq != 12'd2 || dllp_is_nak) seen++;
      tick();
    end
    chk("bp_stable", seen, 0);
    dllp_rdy = 1'b1;
    tick();
    chk("bp_after_vld", {31'd0, dllp_vld}, 0);
    chk("bp_ack_pending", {31'd0, ack_pending}, 1);
    lat_timer_start = 1'b1;
    tick();
    lat_timer_start = 1'b0;
    wait_vld("bp_second_ack", 30);
    chk("bp_second_seq", {20'd0, dllp_seq}, 3);
    ticks(3);
    chk("bp_q_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ack_nak_scheduler.md
Name: ack_nak_scheduler

Overview:
Receive-side Data Link Layer scheduler. It sits between the RX sequence checker and the DLLP transmit arbiter.
- Consumes the checker's per-TLP verdicts: schedule-ack pulse, NAK_SCHEDULED level, requested sequence number and latency-timer start.
- Decides when to emit an Ack or Nak DLLP and which sequence number it carries.
- Implements Ack coalescing, the AckNak latency timer, Nak priority and single-Nak suppression.

Parameters:
SEQ_W, 12, sequence number width
LAT_W, 10, latency timer counter width
ACK_LAT_LIMIT, 255, cycles from the first unacked good TLP until a forced Ack
COALESCE_MAX, 4, good TLPs accumulated before an immediate Ack

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
dl_up  in  1  link in DL_Active; 0 flushes all state
schedule_ack  in  1  one-cycle pulse: good or duplicate TLP accepted
nak_scheduled  in  1  level: NAK_SCHEDULED flag from checker
req_seq_num  in  SEQ_W  seq number for the Ack/Nak, valid with schedule_ack or nak_scheduled
lat_timer_start  in  1  pulse: in-order TLP accepted (starts timer if idle)
dllp_vld  out  1  Ack/Nak DLLP request to TX arbiter
dllp_is_nak  out  1  1 = Nak, 0 = Ack; valid with dllp_vld
dllp_seq  out  SEQ_W  AckNak_Seq_Num field
dllp_rdy  in  1  arbiter accepts; transfer on dllp_vld && dllp_rdy
ack_pending  out  1  unacknowledged good TLPs outstanding
nak_sent  out  1  Nak issued for the current NAK_SCHEDULED episode

Behaviour:
Reset and link-down:
- rst==0 at posedge: all outputs 0, FSM=IDLE, timer=0, coalesce count=0, pending seq=0.
- dl_up==0: identical clear, applied every cycle it is low.

Internal state:
- pend_seq (SEQ_W): last requested Ack sequence number.
- pend_vld: an Ack is owed.
- coal_cnt (3 bits): TLPs absorbed since the last Ack.
- lat_cnt (LAT_W), lat_run: latency timer.

Ack capture (any state):
- schedule_ack → pend_seq<=req_seq_num, pend_vld<=1, coal_cnt saturating +1.
- A newer Ack always overwrites the older one (coalescing).

Latency timer:
- lat_timer_start && !lat_run → lat_run<=1, lat_cnt<=0.
- While lat_run, lat_cnt increments each cycle.
- Expiry: lat_cnt==ACK_LAT_LIMIT-1.
- Timer clears (lat_run<=0) on every accepted Ack or Nak transfer.

Nak capture:
- nak_sent is set on Nak transfer.
- nak_sent clears on the first cycle nak_scheduled==0.
- Nak request condition: nak_scheduled && !nak_sent && FSM not already in SEND_NAK.

FSM states IDLE, ACK_WAIT, SEND_ACK, SEND_NAK:
- IDLE: Nak request → SEND_NAK. Else pend_vld → ACK_WAIT.
- ACK_WAIT: Nak request → SEND_NAK (has priority). Else expiry or coal_cnt>=COALESCE_MAX → SEND_ACK.
- SEND_ACK:
  - Entry loads dllp_seq<=pend_seq, dllp_is_nak<=0, dllp_vld<=1; clears pend_vld and coal_cnt.
  - On transfer: dllp_vld<=0, then go to ACK_WAIT if pend_vld was set again meanwhile, else IDLE.
- SEND_NAK:
  - Entry loads dllp_seq<=req_seq_num, dllp_is_nak<=1, dllp_vld<=1; discards pend_vld and coal_cnt (the Nak acknowledges through NRS-1).
  - On transfer: nak_sent<=1, then IDLE.

Handshake rules:
- dllp_vld, dllp_seq and dllp_is_nak stay stable until transfer.
- Acks arriving mid-request update pend_seq only and never alter the output payload.
- A Nak request during SEND_ACK is served after the Ack transfer completes; the outstanding request is not retracted.

Latency and corner cases:
- dllp_vld is registered. The first cycle after the triggering event is the entry cycle.
- Simultaneous schedule_ack and Nak request: Nak wins; the Ack capture is discarded.
- Sequence numbers are passed through unmodified; there is no arithmetic on seq.

Output flags:
- ack_pending = pend_vld || (FSM==SEND_ACK && dllp_vld).

Decomposition:
- Package dl_pkg:
  - SEQ_W constant.
  - Enum dllp_kind_e {DLLP_ACK, DLLP_NAK}.
  - Enum acknak_state_e {IDLE, ACK_WAIT, SEND_ACK, SEND_NAK}.
- One sub-module, acknak_lat_timer: start, clear, expired, parameter LAT_W/LIMIT.

Test Plan:
- Reset/link-down: rst=0 for 2 cycles → every output 0; then dl_up=0 mid SEND_ACK with dllp_rdy=0 → next cycle dllp_vld=0, ack_pending=0.
- Coalescing, COALESCE_MAX=4: four schedule_ack pulses with seq 0,1,2,3 at 2-cycle spacing, dllp_rdy=1 → exactly one Ack, dllp_seq=3, dllp_is_nak=0.
- Latency expiry, ACK_LAT_LIMIT=16: one pulse (seq 7) with lat_timer_start → Ack seq 7 with dllp_vld at cycle 17 after the start pulse; timer cleared.
- Nak priority/suppression: pending Ack seq 5, then nak_scheduled=1 with req_seq_num=5 → single Nak seq 5, pending Ack dropped, nak_sent=1. Holding nak_scheduled for 50 cycles → no second Nak. Drop it, then re-raise with seq 9 → new Nak seq 9.
- Backpressure: dllp_rdy=0 for 10 cycles during SEND_ACK seq 2 while schedule_ack seq 3 arrives → payload stays seq 2 until rdy. After transfer, FSM→ACK_WAIT and ack_pending=1; a later Ack carries seq 3.
